// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables, a valid/ready request
// port, a 1- or 2-cycle read-response pipeline and an optional clear-after-reset sweep.
module ram_sp_be #(
  parameter int unsigned DW             = 32,
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned BW            = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [BW-1:0] req_be,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] clr_ptr_q;

  logic          xfer_c;
  logic          addr_ok_c;
  logic          rd_fire_c;
  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;
  logic [BW-1:0] wr_be_c;

  logic [DW-1:0] mem [DEPTH];

  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;

  // Next state plus a single write port shared by the clear sweep and user writes.
  always_comb begin
    state_d   = state_q;
    xfer_c    = req_valid && req_ready;
    addr_ok_c = ({1'b0, req_addr} < (AW+1)'(DEPTH));
    rd_fire_c = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = req_addr;
    wr_data_c = req_wdata;
    wr_be_c   = req_be;
    unique case (state_q)
      ST_CLEAR: begin
        wr_en_c   = 1'b1;
        wr_addr_c = clr_ptr_q;
        wr_data_c = '0;
        wr_be_c   = '1;
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        wr_en_c   = xfer_c && req_we && addr_ok_c;
        rd_fire_c = xfer_c && !req_we;
      end
      default: state_d = RST_STATE;
    endcase
  end

  // State, clear pointer and the registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_ptr_q <= '0;
      req_ready <= 1'b0;
      init_busy <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR && state_d == ST_CLEAR) begin
        clr_ptr_q <= clr_ptr_q + AW'(1);
      end
      req_ready <= (state_d == ST_READY);
      init_busy <= (state_d == ST_CLEAR);
    end
  end

  // Byte-masked array write; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_c) begin
      for (int unsigned i = 0; i < BW; i++) begin
        if (wr_be_c[i]) begin
          mem[wr_addr_c][8*i +: 8] <= wr_data_c[8*i +: 8];
        end
      end
    end
  end

  // First read stage: captures pre-edge contents; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire_c;
      if (rd_fire_c) begin
        rd_data_q <= addr_ok_c ? mem[req_addr] : '0;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    // Extra output stage; data only moves when a response passes through.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= '0;
      end else begin
        rsp_valid <= rd_valid_q;
        if (rd_valid_q) begin
          rsp_rdata <= rd_data_q;
        end
      end
    end
  end else begin : g_lat1
    assign rsp_valid = rd_valid_q;
    assign rsp_rdata = rd_data_q;
  end

endmodule

// File: tb/tb_ram_sp_be.sv
// Bench for ram_sp_be: three instances (12 words/lat 1/clear, 16 words/lat 2/clear,
// 16 words/lat 1/no clear) exercised one at a time against a scoreboard of read responses.
module tb_ram_sp_be;

  localparam int unsigned NDUT = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [NDUT];
  logic          req_valid [NDUT];
  logic          req_ready [NDUT];
  logic          req_we    [NDUT];
  logic [AW-1:0] req_addr  [NDUT];
  logic [DW-1:0] req_wdata [NDUT];
  logic [3:0]    req_be    [NDUT];
  logic          rsp_valid [NDUT];
  logic [DW-1:0] rsp_rdata [NDUT];
  logic          init_busy [NDUT];

  ram_sp_be #(.DW(32), .DEPTH(12), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .init_busy(init_busy[0]));

  ram_sp_be #(.DW(32), .DEPTH(16), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .init_busy(init_busy[1]));

  ram_sp_be #(.DW(32), .DEPTH(16), .READ_LAT(1), .CLEAR_ON_RESET(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .init_busy(init_busy[2]));

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] mdl [NDUT][16];
  logic [DW-1:0] last_q;
  int unsigned   cyc;
  int            act;
  int            n_tests;
  int            n_fail;

  function automatic int depth_of(input int d);
    return (d == 0) ? 12 : 16;
  endfunction

  function automatic int unsigned lat_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // One clock: check the response port mid-cycle, then advance past the edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    n_tests++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (rsp_valid[act] !== 1'b1 || rsp_rdata[act] !== e.data) begin
        n_fail++;
        $display("FAIL rsp dut%0d cyc%0d: got valid=%b data=%h, want valid=1 data=%h",
                 act, cyc, rsp_valid[act], rsp_rdata[act], e.data);
      end
      last_q = e.data;
    end else if (rsp_valid[act] !== 1'b0 || rsp_rdata[act] !== last_q) begin
      n_fail++;
      $display("FAIL idle_hold dut%0d cyc%0d: got valid=%b data=%h, want valid=0 data=%h",
               act, cyc, rsp_valid[act], rsp_rdata[act], last_q);
    end
    @(posedge clk);
    cyc++;
    if (rst_n[act] === 1'b0) begin
      sb.delete();
      last_q = '0;
    end
    #1;
  endtask

  // Present one request for one edge and update the model / scoreboard.
  task automatic issue(input int d, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [3:0] be);
    exp_t e;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    if (we) begin
      if (int'(addr) < depth_of(d)) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mdl[d][addr][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end else begin
      e.data = (int'(addr) < depth_of(d)) ? mdl[d][addr] : '0;
      e.due  = cyc + lat_of(d);
      sb.push_back(e);
    end
    step();
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) step();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain dut%0d: %0d responses outstanding, want 0", act, sb.size());
    end
  endtask

  // Reset, then watch the clear sweep (or its absence) cycle by cycle.
  task automatic test_reset(input int d);
    logic clr;
    int   dep;
    clr = (d != 2);
    dep = depth_of(d);
    act = d;
    sb.delete();
    last_q = '0;
    rst_n[d] = 1'b0;
    step();
    step();
    n_tests++;
    if (req_ready[d] !== 1'b0 || init_busy[d] !== clr || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== '0) begin
      n_fail++;
      $display("FAIL reset_state dut%0d: ready=%b busy=%b valid=%b data=%h, want 0 %b 0 0",
               d, req_ready[d], init_busy[d], rsp_valid[d], rsp_rdata[d], clr);
    end
    rst_n[d] = 1'b1;
    if (clr) begin
      for (int i = 0; i < 16; i++) mdl[d][i] = '0;
      for (int i = 1; i <= dep; i++) begin
        // Requests during the sweep must be ignored entirely.
        req_valid[d] = (i <= 3);
        req_we[d]    = (i != 2);
        req_addr[d]  = 4'd3;
        req_wdata[d] = 32'hFFFF_FFFF;
        req_be[d]    = 4'hF;
        step();
        n_tests++;
        if (init_busy[d] !== (i < dep) || req_ready[d] !== (i == dep)) begin
          n_fail++;
          $display("FAIL clear_seq dut%0d edge%0d: busy=%b ready=%b, want %b %b",
                   d, i, init_busy[d], req_ready[d], (i < dep), (i == dep));
        end
      end
      req_valid[d] = 1'b0;
    end else begin
      step();
      n_tests++;
      if (init_busy[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL noclear_ready dut%0d: busy=%b ready=%b, want 0 1", d, init_busy[d], req_ready[d]);
      end
    end
  endtask

  task automatic test_clear_reads(input int d);
    act = d;
    for (int a = 0; a < depth_of(d); a++) begin
      issue(d, 1'b0, AW'(a), '0, 4'h0);
      n_tests++;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL clear_read dut%0d addr%0d: valid=%b data=%h, want 1 00000000",
                 d, a, rsp_valid[d], rsp_rdata[d]);
      end
    end
    drain();
  endtask

  task automatic test_byte_enable(input int d);
    act = d;
    issue(d, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'b1111);
    issue(d, 1'b1, 4'd5, 32'h0000_0011, 4'b0001);
    issue(d, 1'b0, 4'd5, '0, 4'h0);
    n_tests++;
    if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== 32'hDEAD_BE11) begin
      n_fail++;
      $display("FAIL be_low_byte: valid=%b data=%h, want 1 deadbe11", rsp_valid[d], rsp_rdata[d]);
    end
    issue(d, 1'b1, 4'd5, 32'hCAFE_F00D, 4'b0110);
    issue(d, 1'b1, 4'd5, 32'h0000_0000, 4'b0000);
    issue(d, 1'b0, 4'd5, '0, 4'h0);
    n_tests++;
    if (rsp_rdata[d] !== 32'hDEFE_F011) begin
      n_fail++;
      $display("FAIL be_mid_bytes: data=%h, want defef011", rsp_rdata[d]);
    end
    issue(d, 1'b1, 4'd9, 32'h0BAD_F00D, 4'b1111);
    issue(d, 1'b0, 4'd9, '0, 4'h0);
    n_tests++;
    if (rsp_rdata[d] !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL raw_next_cycle: data=%h, want 0badf00d", rsp_rdata[d]);
    end
    step();
    step();
    drain();
  endtask

  task automatic test_out_of_range(input int d);
    act = d;
    for (int a = 0; a < depth_of(d); a++) begin
      issue(d, 1'b1, AW'(a), 32'h1000_0000 + 32'(a), 4'hF);
    end
    issue(d, 1'b1, 4'd13, 32'h0000_00FF, 4'hF);
    issue(d, 1'b1, 4'd15, 32'hFFFF_FFFF, 4'hF);
    issue(d, 1'b0, 4'd13, '0, 4'h0);
    n_tests++;
    if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_read: valid=%b data=%h, want 1 00000000", rsp_valid[d], rsp_rdata[d]);
    end
    for (int a = 0; a < depth_of(d); a++) begin
      issue(d, 1'b0, AW'(a), '0, 4'h0);
      n_tests++;
      if (rsp_rdata[d] !== 32'h1000_0000 + 32'(a)) begin
        n_fail++;
        $display("FAIL oor_intact addr%0d: data=%h, want %h", a, rsp_rdata[d], 32'h1000_0000 + 32'(a));
      end
    end
    drain();
  endtask

  task automatic test_back_to_back(input int d);
    act = d;
    issue(d, 1'b1, 4'd1, 32'h1111_0001, 4'hF);
    issue(d, 1'b1, 4'd2, 32'h2222_0002, 4'hF);
    issue(d, 1'b1, 4'd3, 32'h3333_0003, 4'hF);
    issue(d, 1'b0, 4'd1, '0, 4'h0);
    issue(d, 1'b0, 4'd2, '0, 4'h0);
    issue(d, 1'b0, 4'd3, '0, 4'h0);
    drain();
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h3333_0003) begin
      n_fail++;
      $display("FAIL b2b_hold: valid=%b data=%h, want 0 33330003", rsp_valid[d], rsp_rdata[d]);
    end
  endtask

  task automatic test_reset_inflight(input int d);
    act = d;
    issue(d, 1'b1, 4'd4, 32'hA5A5_0004, 4'hF);
    issue(d, 1'b1, 4'd2, 32'h5A5A_0002, 4'hF);
    issue(d, 1'b0, 4'd4, '0, 4'h0);
    req_valid[d] = 1'b1;
    req_we[d]    = 1'b0;
    req_addr[d]  = 4'd2;
    rst_n[d]     = 1'b0;
    step();
    req_valid[d] = 1'b0;
    rst_n[d]     = 1'b1;
    for (int i = 0; i < 16; i++) mdl[d][i] = '0;
    n_tests++;
    if (init_busy[d] !== 1'b1 || req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_reset: busy=%b ready=%b valid=%b, want 1 0 0",
               init_busy[d], req_ready[d], rsp_valid[d]);
    end
    for (int i = 1; i <= 16; i++) step();
    n_tests++;
    if (init_busy[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL reclear_done: busy=%b ready=%b, want 0 1", init_busy[d], req_ready[d]);
    end
    issue(d, 1'b0, 4'd4, '0, 4'h0);
    issue(d, 1'b0, 4'd2, '0, 4'h0);
    drain();
    n_tests++;
    if (rsp_rdata[d] !== 32'h0) begin
      n_fail++;
      $display("FAIL reclear_data: data=%h, want 00000000", rsp_rdata[d]);
    end
  endtask

  task automatic test_no_clear(input int d);
    act = d;
    issue(d, 1'b1, 4'd7, 32'h1234_5678, 4'hF);
    issue(d, 1'b1, 4'd0, 32'hABCD_EF01, 4'hF);
    rst_n[d] = 1'b0;
    step();
    step();
    n_tests++;
    if (req_ready[d] !== 1'b0 || init_busy[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL noclear_in_reset: ready=%b busy=%b, want 0 0", req_ready[d], init_busy[d]);
    end
    rst_n[d] = 1'b1;
    step();
    n_tests++;
    if (req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL noclear_first_cycle: ready=%b, want 1", req_ready[d]);
    end
    issue(d, 1'b0, 4'd7, '0, 4'h0);
    n_tests++;
    if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL noclear_keep: valid=%b data=%h, want 1 12345678", rsp_valid[d], rsp_rdata[d]);
    end
    issue(d, 1'b0, 4'd0, '0, 4'h0);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    act     = 0;
    last_q  = '0;
    for (int d = 0; d < int'(NDUT); d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
    end
    test_reset(0);
    test_clear_reads(0);
    test_byte_enable(0);
    test_out_of_range(0);
    test_reset(1);
    test_back_to_back(1);
    test_reset_inflight(1);
    test_reset(2);
    test_no_clear(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
